// File: rtl/boreal_digest_engine.sv
`default_nettype none
// ============================================================================
// Module      : boreal_digest_engine
// Description : Multi-cycle 32-bit running digest for the boot-ROM hash
//               interface. Each accepted word is mixed into the digest over
//               ROUNDS cycles, one round per cycle. The engine reports
//               readiness with a registered handshake and keeps a sticky
//               protocol-error flag.
// Ports       : clk        - single clock; state updates on the rising edge
//               rst        - asynchronous active-high reset
//               start      - pulse; reloads the digest with IV, clears count/err
//               update     - pulse; absorb data_in when ready
//               data_in    - word to absorb (sampled only on accepted update)
//               hash_out   - registered digest
//               ready      - registered; high when an update can be accepted
//               word_count - words absorbed since the last start (wraps)
//               err        - sticky protocol-error flag
// Revision    : 1.0 - initial release
// ============================================================================
module boreal_digest_engine #(
    parameter int unsigned ROUNDS = 4,
    parameter logic [31:0] IV     = 32'h6A09E667,
    parameter logic [31:0] KBASE  = 32'h9E3779B9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        update,
    input  logic [31:0] data_in,
    output logic [31:0] hash_out,
    output logic        ready,
    output logic [15:0] word_count,
    output logic        err
);

    localparam logic [1:0] c_st_uninit = 2'd0;
    localparam logic [1:0] c_st_ready  = 2'd1;
    localparam logic [1:0] c_st_busy   = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_hash;     // published digest
    logic [31:0] r_h;        // working digest while a word is in flight
    logic [31:0] r_w;        // latched input word
    logic [3:0]  r_round;    // current round index, 0..ROUNDS-1
    logic        r_ready;
    logic [15:0] r_count;
    logic        r_err;

    logic [31:0] w_k;
    logic [31:0] w_t;
    logic [31:0] w_h_next;
    logic        w_last;

    // One mixing round: t = (H ^ W) + K_r, H' = rotl(t,5) ^ (t >> 3)
    assign w_k      = KBASE + {28'd0, r_round};
    assign w_t      = (r_h ^ r_w) + w_k;
    assign w_h_next = {w_t[26:0], w_t[31:27]} ^ (w_t >> 3);
    assign w_last   = (r_round == 4'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_uninit;
            r_hash  <= 32'd0;
            r_h     <= 32'd0;
            r_w     <= 32'd0;
            r_round <= 4'd0;
            r_ready <= 1'b0;
            r_count <= 16'd0;
            r_err   <= 1'b0;
        end else if (start) begin
            // start has priority in every state: any word in flight is
            // discarded and a coincident update is silently dropped.
            r_state <= c_st_ready;
            r_hash  <= IV;
            r_h     <= IV;
            r_round <= 4'd0;
            r_ready <= 1'b1;
            r_count <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_uninit: begin
                    if (update) begin
                        r_err <= 1'b1;
                    end
                end
                c_st_ready: begin
                    if (update) begin
                        r_w     <= data_in;
                        r_h     <= r_hash;
                        r_round <= 4'd0;
                        r_ready <= 1'b0;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    // An update here is a protocol error; the word in
                    // flight continues untouched.
                    if (update) begin
                        r_err <= 1'b1;
                    end
                    r_h <= w_h_next;
                    if (w_last) begin
                        r_hash  <= w_h_next;
                        r_count <= r_count + 16'd1;
                        r_ready <= 1'b1;
                        r_state <= c_st_ready;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_uninit;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign hash_out   = r_hash;
    assign ready      = r_ready;
    assign word_count = r_count;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_boreal_digest_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_boreal_digest_engine
// Description : Self-checking bench for boreal_digest_engine. Two instances
//               (ROUNDS=1 and ROUNDS=4) are driven by directed steps with
//               random data words and compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boreal_digest_engine;

    localparam logic [31:0] c_iv    = 32'h6A09E667;
    localparam logic [31:0] c_kbase = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start1 = 1'b0, update1 = 1'b0;
    logic [31:0] data1  = 32'd0;
    logic [31:0] hash1;
    logic        ready1, err1;
    logic [15:0] wc1;

    logic        start4 = 1'b0, update4 = 1'b0;
    logic [31:0] data4  = 32'd0;
    logic [31:0] hash4;
    logic        ready4, err4;
    logic [15:0] wc4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    boreal_digest_engine #(.ROUNDS(1), .IV(c_iv), .KBASE(c_kbase)) d1 (
        .clk(clk), .rst(rst), .start(start1), .update(update1), .data_in(data1),
        .hash_out(hash1), .ready(ready1), .word_count(wc1), .err(err1)
    );

    boreal_digest_engine #(.ROUNDS(4), .IV(c_iv), .KBASE(c_kbase)) d4 (
        .clk(clk), .rst(rst), .start(start4), .update(update4), .data_in(data4),
        .hash_out(hash4), .ready(ready4), .word_count(wc4), .err(err4)
    );

    // Reference: absorb one word into a digest over a given number of rounds.
    function automatic logic [31:0] absorb(input logic [31:0] h, input logic [31:0] w,
                                           input int rounds);
        logic [31:0] t;
        for (int r = 0; r < rounds; r++) begin
            t = (h ^ w) + c_kbase + 32'(r);
            h = ((t << 5) | (t >> 27)) ^ (t >> 3);
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] exp_h;
        logic [15:0] exp_wc;
        logic [31:0] d;
        logic [31:0] held;

        // ---- reset values ----
        ticks(2);
        chk("rst_hash", hash4, 32'd0);
        chk("rst_ready", {31'd0, ready4}, 32'd0);
        chk("rst_wc", {16'd0, wc4}, 32'd0);
        chk("rst_err", {31'd0, err4}, 32'd0);
        rst = 1'b0;
        tick();

        // ---- update in UNINIT ----
        update4 = 1'b1; data4 = $urandom;
        tick();
        update4 = 1'b0;
        chk("uninit_err", {31'd0, err4}, 32'd1);
        chk("uninit_hash", hash4, 32'd0);
        chk("uninit_ready", {31'd0, ready4}, 32'd0);

        // ---- start: reload, clears err ----
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("start_hash", hash4, c_iv);
        chk("start_ready", {31'd0, ready4}, 32'd1);
        chk("start_wc", {16'd0, wc4}, 32'd0);
        chk("start_err_clr", {31'd0, err4}, 32'd0);
        exp_h = c_iv; exp_wc = 16'd0;

        // ---- single word, ROUNDS=1, known vector ----
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        update1 = 1'b1; data1 = c_iv;
        tick();
        update1 = 1'b0;
        chk("r1_ready_low", {31'd0, ready1}, 32'd0);
        tick();
        chk("r1_hash_vec", hash1, 32'hD529D804);
        chk("r1_hash_model", hash1, absorb(c_iv, c_iv, 1));
        chk("r1_wc", {16'd0, wc1}, 32'd1);
        chk("r1_ready", {31'd0, ready1}, 32'd1);

        // ---- latency, ROUNDS=4 ----
        d = $urandom;
        update4 = 1'b1; data4 = d;
        tick();
        update4 = 1'b0; data4 = $urandom;
        held = exp_h;
        exp_h = absorb(exp_h, d, 4); exp_wc++;
        for (int i = 0; i < 4; i++) begin
            chk("lat_ready_low", {31'd0, ready4}, 32'd0);
            chk("lat_hash_hold", hash4, held);
            tick();
        end
        chk("lat_ready", {31'd0, ready4}, 32'd1);
        chk("lat_hash", hash4, exp_h);
        chk("lat_wc", {16'd0, wc4}, {16'd0, exp_wc});

        // ---- back-to-back word in the first ready cycle ----
        d = $urandom;
        update4 = 1'b1; data4 = d;
        tick();
        update4 = 1'b0;
        exp_h = absorb(exp_h, d, 4); exp_wc++;
        chk("b2b_ready_low", {31'd0, ready4}, 32'd0);
        ticks(4);
        chk("b2b_hash", hash4, exp_h);
        chk("b2b_wc", {16'd0, wc4}, 32'd2);

        // ---- random words ----
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            update4 = 1'b1; data4 = d;
            tick();
            update4 = 1'b0; data4 = $urandom;
            ticks(3 + $urandom_range(1, 3));
            exp_h = absorb(exp_h, d, 4); exp_wc++;
            chk("rand_hash", hash4, exp_h);
            chk("rand_wc", {16'd0, wc4}, {16'd0, exp_wc});
        end

        // ---- update while BUSY ----
        d = $urandom;
        update4 = 1'b1; data4 = d;
        tick();
        data4 = ~d;
        tick();
        update4 = 1'b0;
        ticks(3);
        exp_h = absorb(exp_h, d, 4); exp_wc++;
        chk("busy_upd_err", {31'd0, err4}, 32'd1);
        chk("busy_upd_hash", hash4, exp_h);
        chk("busy_upd_wc", {16'd0, wc4}, {16'd0, exp_wc});

        // ---- start clears err ----
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("clr_err", {31'd0, err4}, 32'd0);
        chk("clr_hash", hash4, c_iv);
        exp_h = c_iv; exp_wc = 16'd0;

        // ---- start mid-BUSY aborts ----
        update4 = 1'b1; data4 = $urandom;
        tick();
        update4 = 1'b0;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("abort_hash", hash4, c_iv);
        chk("abort_wc", {16'd0, wc4}, 32'd0);
        chk("abort_ready", {31'd0, ready4}, 32'd1);
        ticks(4);
        chk("abort_quiet", hash4, c_iv);
        d = $urandom;
        update4 = 1'b1; data4 = d;
        tick();
        update4 = 1'b0;
        ticks(4);
        chk("abort_next", hash4, absorb(c_iv, d, 4));

        // ---- start and update in the same cycle ----
        start4 = 1'b1; update4 = 1'b1; data4 = $urandom;
        tick();
        start4 = 1'b0; update4 = 1'b0;
        chk("coll_wc", {16'd0, wc4}, 32'd0);
        chk("coll_err", {31'd0, err4}, 32'd0);
        chk("coll_ready", {31'd0, ready4}, 32'd1);
        ticks(5);
        chk("coll_hash", hash4, c_iv);
        chk("coll_wc_late", {16'd0, wc4}, 32'd0);

        // ---- reset mid-word ----
        update4 = 1'b1; data4 = $urandom;
        tick();
        update4 = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mrst_hash", hash4, 32'd0);
        chk("mrst_ready", {31'd0, ready4}, 32'd0);
        chk("mrst_wc", {16'd0, wc4}, 32'd0);
        tick();
        rst = 1'b0;
        ticks(5);
        chk("mrst_uninit_ready", {31'd0, ready4}, 32'd0);
        update4 = 1'b1;
        tick();
        update4 = 1'b0;
        chk("mrst_uninit_err", {31'd0, err4}, 32'd1);

        // ---- word_count wrap ----
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        force d4.r_count = 16'hFFFF;
        tick();
        release d4.r_count;
        chk("wrap_pre", {16'd0, wc4}, 32'h0000FFFF);
        d = $urandom;
        update4 = 1'b1; data4 = d;
        tick();
        update4 = 1'b0;
        ticks(4);
        chk("wrap_wc", {16'd0, wc4}, 32'd0);
        chk("wrap_hash", hash4, absorb(c_iv, d, 4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
